ram_bridge_tx: RTL and testbench

UART-side read responder that complements the write bridge on the program/data RAM debug port. It parses `R` read frames from the `uart_rx` byte stream and drives the RAM read address. It then captures the 32-bit read word and streams it back, little-endian, to a `uart_tx` through a valid/ready handshake. It skips `W` write frames so it can share the receive stream with the write bridge.

---
 rtl/ram_bridge_tx.sv | 172 +++++++++++++++++
 tb/tb_ram_bridge_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bridge_tx.sv
// UART-side RAM read responder: parses 'R' frames, drives the RAM read address,
// captures the read word and streams it little-endian to uart_tx; skips 'W' frames.
module ram_bridge_tx #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic [31:0] addr_out,
  input  logic [31:0] mem_data_in,
  output logic        busy_out,
  output logic [7:0]  tx_data_out,
  output logic        tx_valid_out,
  input  logic        tx_ready_in
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_SKIP = 3'd2,
    ST_READ = 3'd3,
    ST_SEND = 3'd4
  } state_t;

  localparam logic [2:0] LAT_MAX   = 3'(READ_LATENCY);
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] CMD_WRITE = 8'h57;

  state_t      state_r, state_s;
  logic [2:0]  cnt_r, cnt_s;
  logic [2:0]  lat_r, lat_s;
  logic [23:0] abuf_r, abuf_s;
  logic [31:0] addr_s;
  logic [31:0] resp_r, resp_s;
  logic [1:0]  idx_r, idx_s;
  logic [7:0]  tx_data_s;
  logic        tx_valid_s;
  logic        accept_s;

  assign accept_s = tx_valid_out && tx_ready_in;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    case (i)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // State register; busy is registered alongside the state it reflects
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r  <= ST_IDLE;
      busy_out <= 1'b0;
    end else begin
      state_r  <= state_s;
      busy_out <= (state_s != ST_IDLE);
    end
  end

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (valid_in && data_in == CMD_READ)       state_s = ST_ADDR;
        else if (valid_in && data_in == CMD_WRITE) state_s = ST_SKIP;
        else                                       state_s = ST_IDLE;
      end
      ST_ADDR: begin
        if (valid_in && cnt_r == 3'd3) state_s = ST_READ;
        else                           state_s = ST_ADDR;
      end
      ST_SKIP: begin
        if (valid_in && cnt_r == 3'd7) state_s = ST_IDLE;
        else                           state_s = ST_SKIP;
      end
      ST_READ: begin
        if (lat_r == LAT_MAX) state_s = ST_SEND;
        else                  state_s = ST_READ;
      end
      ST_SEND: begin
        if (accept_s && idx_r == 2'd3) state_s = ST_IDLE;
        else                           state_s = ST_SEND;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of counters, address/response words and tx outputs
  always_comb begin
    cnt_s      = cnt_r;
    lat_s      = lat_r;
    abuf_s     = abuf_r;
    addr_s     = addr_out;
    resp_s     = resp_r;
    idx_s      = idx_r;
    tx_data_s  = tx_data_out;
    tx_valid_s = tx_valid_out;
    case (state_r)
      ST_IDLE: begin
        if (valid_in) cnt_s = 3'd0;
        else          cnt_s = cnt_r;
      end
      ST_ADDR: begin
        // Bytes shift in from the top so b0 ends up in the low byte
        if (valid_in && cnt_r == 3'd3) begin
          addr_s = {data_in, abuf_r};
          lat_s  = 3'd0;
        end else if (valid_in) begin
          abuf_s = {data_in, abuf_r[23:8]};
          cnt_s  = cnt_r + 3'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_SKIP: begin
        if (valid_in) cnt_s = cnt_r + 3'd1;
        else          cnt_s = cnt_r;
      end
      ST_READ: begin
        if (lat_r == LAT_MAX) begin
          resp_s     = mem_data_in;
          idx_s      = 2'd0;
          tx_data_s  = mem_data_in[7:0];
          tx_valid_s = 1'b1;
        end else begin
          lat_s = lat_r + 3'd1;
        end
      end
      ST_SEND: begin
        if (accept_s && idx_r == 2'd3) begin
          tx_valid_s = 1'b0;
        end else if (accept_s) begin
          idx_s     = idx_r + 2'd1;
          tx_data_s = word_byte(resp_r, idx_r + 2'd1);
        end else begin
          tx_valid_s = tx_valid_out;
        end
      end
      default: tx_valid_s = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_r        <= 3'd0;
      lat_r        <= 3'd0;
      abuf_r       <= 24'd0;
      addr_out     <= 32'd0;
      resp_r       <= 32'd0;
      idx_r        <= 2'd0;
      tx_data_out  <= 8'd0;
      tx_valid_out <= 1'b0;
    end else begin
      cnt_r        <= cnt_s;
      lat_r        <= lat_s;
      abuf_r       <= abuf_s;
      addr_out     <= addr_s;
      resp_r       <= resp_s;
      idx_r        <= idx_s;
      tx_data_out  <= tx_data_s;
      tx_valid_out <= tx_valid_s;
    end
  end

endmodule

// File: tb/tb_ram_bridge_tx.sv
// Scoreboard bench for ram_bridge_tx: two instances (READ_LATENCY 1 and 2) share
// the byte stream; a RAM model with configurable true latency feeds each one.
module tb_ram_bridge_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, valid = 1'b0, tx_ready = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [31:0] addr1, addr2, mem1, mem2;
  logic        busy1, busy2, tv1, tv2;
  logic [7:0]  td1, td2;

  ram_bridge_tx #(.READ_LATENCY(1)) dut1 (
    .clk_in(clk), .rst_in(rst_n), .data_in(din), .valid_in(valid), .addr_out(addr1),
    .mem_data_in(mem1), .busy_out(busy1), .tx_data_out(td1), .tx_valid_out(tv1),
    .tx_ready_in(tx_ready));
  ram_bridge_tx #(.READ_LATENCY(2)) dut2 (
    .clk_in(clk), .rst_in(rst_n), .data_in(din), .valid_in(valid), .addr_out(addr2),
    .mem_data_in(mem2), .busy_out(busy2), .tx_data_out(td2), .tx_valid_out(tv2),
    .tx_ready_in(tx_ready));

  localparam logic [31:0] GARB = 32'h0BADF00D;
  localparam logic [31:0] A0   = 32'h00020010;

  int checks = 0, failures = 0;
  logic [7:0] q0[$], q1[$];
  int lram1 = 1, lram2 = 2, age1 = 0, age2 = 0;
  logic [31:0] last1, last2, model_addr = 32'd0;
  int rmode = 0, stall = 0;
  int accepts[2] = '{0, 0};
  int vcount[2]  = '{0, 0};
  logic prev_v[2] = '{1'b0, 1'b0};
  logic prev_r[2] = '{1'b0, 1'b0};
  logic [7:0] prev_d[2] = '{8'h00, 8'h00};

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [11:0] i;
    i = a[13:2];
    if (i == 12'h004) return 32'hDEADBEEF;
    return {4'hC, i, 4'h3, ~i};
  endfunction

  // RAM model: word becomes valid once the address has been stable for lram edges
  always @(negedge clk) begin
    if (addr1 !== last1) begin age1 = 0; last1 = addr1; end else if (age1 < 8) age1++;
    if (addr2 !== last2) begin age2 = 0; last2 = addr2; end else if (age2 < 8) age2++;
    mem1 = (age1 >= lram1) ? mem_word(addr1) : GARB;
    mem2 = (age2 >= lram2) ? mem_word(addr2) : GARB;
  end

  // tx_ready driver: 0 always high, 1 random, 2 five-cycle stall once dut1 presents
  always @(posedge clk) begin
    #1;
    case (rmode)
      1: tx_ready = ($urandom_range(0, 3) != 0);
      2: if (tv1 && stall < 5) begin tx_ready = 1'b0; stall++; end else tx_ready = 1'b1;
      default: tx_ready = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [7:0] dat);
    logic [7:0] e;
    if (prev_v[d] && !prev_r[d]) begin
      checks++;
      if (!(v === 1'b1 && dat === prev_d[d])) begin
        failures++;
        $display("FAIL hold_dut%0d actual=%b/%h required=1/%h", d + 1, v, dat, prev_d[d]);
      end
    end
    if (v) vcount[d]++;
    if (v && tx_ready) begin
      checks++;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        failures++;
        $display("FAIL unexpected_byte_dut%0d actual=%h required=none", d + 1, dat);
      end else begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (dat !== e) begin
          failures++;
          $display("FAIL tx_byte_dut%0d actual=%h required=%h", d + 1, dat, e);
        end
      end
      accepts[d]++;
    end
    prev_v[d] = v; prev_r[d] = tx_ready; prev_d[d] = dat;
  endtask

  // Monitor: compares every accepted byte against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, tv1, td1);
      mon(1, tv2, td2);
    end else begin
      prev_v[0] = 1'b0; prev_v[1] = 1'b0;
    end
  end

  task automatic push_resp(input logic [31:0] w1, input logic [31:0] w2);
    for (int i = 0; i < 4; i++) begin
      q0.push_back(w1[8*i +: 8]);
      q1.push_back(w2[8*i +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax);
    repeat ($urandom_range(0, gmax)) @(posedge clk);
    @(posedge clk); #1; din = b; valid = 1'b1;
    @(posedge clk); #1; valid = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] a, input int gmax);
    send_byte(8'h52, gmax);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], gmax);
    model_addr = a;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk); #1;
      if (!busy1 && !busy2 && !tv1 && !tv2) done = 1'b1;
    end
    chk({name, "_idle"}, {31'd0, done}, 32'd1);
    chk({name, "_queue_empty"}, q0.size() + q1.size(), 32'd0);
    chk({name, "_addr1"}, addr1, model_addr);
    chk({name, "_addr2"}, addr2, model_addr);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, v1, base;
    logic [31:0] a;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", addr1, 32'd0);
    chk("rst_busy", {31'd0, busy1}, 32'd0);
    chk("rst_tx_valid", {31'd0, tv1}, 32'd0);
    chk("rst_tx_data", {24'd0, td1}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // basic read, ready tied high
    v0 = vcount[0]; v1 = vcount[1];
    push_resp(32'hDEADBEEF, 32'hDEADBEEF);
    send_read(A0, 0);
    chk("basic_addr_after_e0", addr1, A0);
    wait_idle("basic");
    chk("basic_valid_cycles1", vcount[0] - v0, 32'd4);
    chk("basic_valid_cycles2", vcount[1] - v1, 32'd4);

    // backpressure: 5 stalled cycles after tx_valid rises
    stall = 0; rmode = 2;
    v0 = vcount[0]; v1 = vcount[1];
    push_resp(32'hDEADBEEF, 32'hDEADBEEF);
    send_read(A0, 0);
    wait_idle("backpressure");
    chk("bp_valid_cycles1", vcount[0] - v0, 32'd9);
    chk("bp_valid_cycles2", vcount[1] - v1, 32'd8);
    rmode = 0;

    // write frame containing 'R' bytes is skipped entirely
    send_byte(8'h57, 0);
    for (int i = 0; i < 5; i++) send_byte(8'h52, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
    chk("skip_busy_after", {31'd0, busy1}, 32'd0);
    wait_idle("skip");
    push_resp(32'hDEADBEEF, 32'hDEADBEEF);
    send_read(A0, 1);
    wait_idle("after_skip");

    // junk in IDLE, then 'R' injected during SEND is dropped
    send_byte(8'h00, 0);
    chk("junk00_busy", {31'd0, busy1}, 32'd0);
    send_byte(8'hFF, 0);
    chk("junkFF_busy", {31'd0, busy1}, 32'd0);
    a = 32'h00001230;
    push_resp(mem_word(a), mem_word(a));
    send_read(a, 0);
    for (int n = 0; n < 50 && !tv1; n++) begin @(negedge clk); #1; end
    chk("drop_saw_valid", {31'd0, tv1}, 32'd1);
    send_byte(8'h52, 0);
    wait_idle("drop_in_send");

    // reset after two accepted bytes discards the response
    base = accepts[0];
    push_resp(mem_word(32'h00000444), mem_word(32'h00000444));
    send_read(32'h00000444, 0);
    for (int n = 0; n < 100 && accepts[0] < base + 2; n++) begin @(negedge clk); #1; end
    chk("rst_mid_two_accepted", accepts[0] - base, 32'd2);
    @(posedge clk); #1; rst_n = 1'b0;
    q0.delete(); q1.delete();
    model_addr = 32'd0;
    @(posedge clk); @(negedge clk);
    chk("rst_mid_tx_valid", {30'd0, tv1, tv2}, 32'd0);
    chk("rst_mid_addr", addr1, 32'd0);
    chk("rst_mid_busy", {30'd0, busy1, busy2}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    push_resp(32'hDEADBEEF, 32'hDEADBEEF);
    send_read(A0, 0);
    wait_idle("after_reset");

    // RAM with true latency 2: only the READ_LATENCY=2 instance captures the real word
    lram1 = 2; lram2 = 2;
    a = 32'h00003A7C;
    push_resp(GARB, mem_word(a));
    send_read(a, 0);
    wait_idle("latency_capture");
    lram1 = 1;

    // randomized mix of read frames, write frames and junk with random ready
    rmode = 1;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          a = $urandom;
          push_resp(mem_word(a), mem_word(a));
          send_read(a, 2);
        end
        6, 7: begin
          send_byte(8'h57, 2);
          for (int i = 0; i < 8; i++) send_byte(8'($urandom), 2);
        end
        default: begin
          b = 8'($urandom);
          if (b == 8'h52 || b == 8'h57) b = 8'h00;
          send_byte(b, 2);
        end
      endcase
      wait_idle("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
